lpm_table_responder: RTL and testbench



---
 rtl/lpm_table_responder.sv | 133 +++++++++++++
 tb/tb_lpm_table_responder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lpm_table_responder.sv
// Prefix-trie table responder for the LPM lookup engine: in-order, fixed-latency
// reads through a credit-limited pipeline and response queue, plus a table load port.
module lpm_table_responder #(
  parameter int ADDR_W      = 8,
  parameter int LATENCY     = 3,
  parameter int OUTSTANDING = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ifc_req__ENA,
  input  logic [31:0]       ifc_req_v,
  output logic              ifc_req__RDY,
  output logic [31:0]       ifc_resValue,
  output logic              ifc_resValue__RDY,
  input  logic              ifc_resAccept__ENA,
  output logic              ifc_resAccept__RDY,
  input  logic              load_write__ENA,
  input  logic [ADDR_W-1:0] load_write_addr,
  input  logic [31:0]       load_write_data,
  output logic              load_write__RDY
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = $clog2(OUTSTANDING) + 1;
  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_idx;
  logic [31:0]       table_mem [DEPTH];
  logic [LATENCY-1:0] p_valid;
  logic [31:0]       p_data [LATENCY];
  logic [31:0]       q_mem [OUTSTANDING];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  q_count;
  logic [CNT_W-1:0]  occupancy;

  logic              req_acc;
  logic              pop;
  logic              push;
  logic [ADDR_W-1:0] req_idx;
  logic              unused_req_hi;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_waddr;
  logic [31:0]       tbl_wdata;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every ready is a function of registered state only, never of an ENA input.
  assign ifc_req__RDY       = (state == RUN) && (occupancy < CNT_W'(OUTSTANDING));
  assign load_write__RDY    = (state == RUN);
  assign ifc_resValue__RDY  = (q_count != '0);
  assign ifc_resAccept__RDY = ifc_resValue__RDY;
  assign ifc_resValue       = ifc_resValue__RDY ? q_mem[rd_ptr] : '0;

  assign req_idx       = ifc_req_v[ADDR_W-1:0];
  assign unused_req_hi = ^ifc_req_v[31:ADDR_W];
  assign req_acc       = ifc_req__ENA && ifc_req__RDY;
  assign pop           = ifc_resAccept__ENA && ifc_resValue__RDY;
  assign push          = p_valid[LATENCY-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = load_write_addr;
    tbl_wdata = load_write_data;
    if (state == CLEAR) begin
      tbl_we    = 1'b1;
      tbl_waddr = clr_idx;
      tbl_wdata = '0;
    end else if (load_write__ENA) begin
      tbl_we = 1'b1;
    end
  end

  // NOTE: storage arrays carry no reset; the clear sweep and the valid/pointer state define them.
  always_ff @(posedge CLK) begin
    if (tbl_we) table_mem[tbl_waddr] <= tbl_wdata;
    // A read in the same cycle as a write to that index sees the old word.
    if (req_acc) p_data[0] <= table_mem[req_idx];
    for (int k = 1; k < LATENCY; k++) p_data[k] <= p_data[k-1];
    if (push) q_mem[wr_ptr] <= p_data[LATENCY-1];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      p_valid   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      q_count   <= '0;
      occupancy <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == '1) state <= RUN;
        end
        RUN:     state <= RUN;
        default: state <= CLEAR;
      endcase

      p_valid[0] <= req_acc;
      for (int k = 1; k < LATENCY; k++) p_valid[k] <= p_valid[k-1];

      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);

      case ({push, pop})
        2'b10:   q_count <= q_count + 1'b1;
        2'b01:   q_count <= q_count - 1'b1;
        default: q_count <= q_count;
      endcase

      case ({req_acc, pop})
        2'b10:   occupancy <= occupancy + 1'b1;
        2'b01:   occupancy <= occupancy - 1'b1;
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Popping an empty queue is a protocol violation by the consumer; the pop is ignored.
  a_no_empty_pop: assert property (@(posedge CLK) disable iff (!nRST)
                                   ifc_resAccept__ENA |-> ifc_resValue__RDY);

endmodule

// File: tb/tb_lpm_table_responder.sv
// Directed self-checking bench for lpm_table_responder: clear sweep, read latency,
// read-during-write, credit limit, in-order responses and reset mid-flight.
module tb_lpm_table_responder;

  localparam int ADDR_W = 8;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ifc_req__ENA;
  logic [31:0]       ifc_req_v;
  logic              ifc_req__RDY;
  logic [31:0]       ifc_resValue;
  logic              ifc_resValue__RDY;
  logic              ifc_resAccept__ENA;
  logic              ifc_resAccept__RDY;
  logic              load_write__ENA;
  logic [ADDR_W-1:0] load_write_addr;
  logic [31:0]       load_write_data;
  logic              load_write__RDY;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  lpm_table_responder #(.ADDR_W(ADDR_W), .LATENCY(3), .OUTSTANDING(4)) dut (
    .CLK                (CLK),
    .nRST               (nRST),
    .ifc_req__ENA       (ifc_req__ENA),
    .ifc_req_v          (ifc_req_v),
    .ifc_req__RDY       (ifc_req__RDY),
    .ifc_resValue       (ifc_resValue),
    .ifc_resValue__RDY  (ifc_resValue__RDY),
    .ifc_resAccept__ENA (ifc_resAccept__ENA),
    .ifc_resAccept__RDY (ifc_resAccept__RDY),
    .load_write__ENA    (load_write__ENA),
    .load_write_addr    (load_write_addr),
    .load_write_data    (load_write_data),
    .load_write__RDY    (load_write__RDY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data);
    load_write__ENA = 1'b1;
    load_write_addr = addr;
    load_write_data = data;
    tick();
    load_write__ENA = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [31:0] addr);
    check({tag, "_req_rdy"}, ifc_req__RDY, 1'b1);
    ifc_req__ENA = 1'b1;
    ifc_req_v    = addr;
    tick();
    ifc_req__ENA = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [31:0] exp);
    int n = 0;
    while (!ifc_resValue__RDY && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_val_rdy"}, ifc_resValue__RDY, 1'b1);
    check({tag, "_acc_rdy"}, ifc_resAccept__RDY, 1'b1);
    check(tag, ifc_resValue, exp);
    ifc_resAccept__ENA = ifc_resValue__RDY;
    tick();
    ifc_resAccept__ENA = 1'b0;
  endtask

  // Single request into an empty pipeline: checks latency, word and queue drain.
  task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int n = 0;
    issue(tag, addr);
    while (!ifc_resValue__RDY && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, n, 3);
    check(tag, ifc_resValue, exp);
    ifc_resAccept__ENA = 1'b1;
    tick();
    ifc_resAccept__ENA = 1'b0;
    check({tag, "_empty"}, ifc_resValue__RDY, 1'b0);
  endtask

  task automatic wait_clear(input string tag);
    int n = 0;
    bit saw = 1'b0;
    while (!ifc_req__RDY && n < 1000) begin
      if (ifc_resValue__RDY || ifc_resAccept__RDY || load_write__RDY) saw = 1'b1;
      tick();
      n++;
    end
    check({tag, "_cycles"}, n, 256);
    check({tag, "_rdy_during"}, saw, 1'b0);
    check({tag, "_wr_rdy"}, load_write__RDY, 1'b1);
  endtask

  initial begin
    int occ;
    int full_pops;
    bit acc;
    bit pp;

    nRST               = 1'b0;
    ifc_req__ENA       = 1'b0;
    ifc_req_v          = '0;
    ifc_resAccept__ENA = 1'b0;
    load_write__ENA    = 1'b0;
    load_write_addr    = '0;
    load_write_data    = '0;
    tick();
    tick();
    check("rst_req_rdy", ifc_req__RDY, 1'b0);
    check("rst_wr_rdy", load_write__RDY, 1'b0);
    check("rst_val_rdy", ifc_resValue__RDY, 1'b0);
    check("rst_acc_rdy", ifc_resAccept__RDY, 1'b0);
    check("rst_value", ifc_resValue, 32'h0);

    nRST = 1'b1;
    wait_clear("clear1");
    read_check("rd37", 32'h37, 32'h0);

    // Write then read one cycle later sees the new word.
    do_write(8'h10, 32'h0000_0A01);
    read_check("rd10", 32'h10, 32'h0000_0A01);

    // Same-cycle write and read of 0x20 returns the old word; next cycle the new one.
    check("rdw_req_rdy", ifc_req__RDY, 1'b1);
    load_write__ENA = 1'b1;
    load_write_addr = 8'h20;
    load_write_data = 32'hDEAD_BEEF;
    ifc_req__ENA    = 1'b1;
    ifc_req_v       = 32'h20;
    tick();
    load_write__ENA = 1'b0;
    tick();
    ifc_req__ENA = 1'b0;
    pop_expect("rdw_old", 32'h0);
    pop_expect("rdw_new", 32'hDEAD_BEEF);

    // Credit limit: four requests fill the window; first pop returns a credit.
    for (int i = 1; i <= 4; i++) do_write(ADDR_W'(i), 32'h11 * i);
    do_write(8'h05, 32'h55);
    for (int i = 1; i <= 4; i++) begin
      check("fill_req_rdy", ifc_req__RDY, 1'b1);
      ifc_req__ENA = 1'b1;
      ifc_req_v    = i;
      tick();
    end
    ifc_req__ENA = 1'b0;
    check("full_req_rdy", ifc_req__RDY, 1'b0);
    pop_expect("order1", 32'h11);
    check("credit_back", ifc_req__RDY, 1'b1);
    pop_expect("order2", 32'h22);
    pop_expect("order3", 32'h33);
    pop_expect("order4", 32'h44);

    // Upper request bits are ignored.
    read_check("rd_hi_bits", 32'h0001_0005, 32'h55);

    // Steady state: fill, then request whenever ready and pop whenever valid.
    for (int i = 1; i <= 4; i++) begin
      check("ss_fill_rdy", ifc_req__RDY, 1'b1);
      ifc_req__ENA = 1'b1;
      ifc_req_v    = i;
      exp_q.push_back(32'h11 * i);
      tick();
    end
    ifc_req__ENA = 1'b0;
    occ = 4;
    full_pops = 0;
    for (int c = 0; c < 24; c++) begin
      check("ss_req_rdy", ifc_req__RDY, occ < 4);
      acc = ifc_req__RDY;
      pp  = ifc_resValue__RDY;
      if (pp) begin
        if (exp_q.size() == 0) begin
          check("ss_spurious", ifc_resValue__RDY, 1'b0);
          pp = 1'b0;
        end else begin
          check("ss_val", ifc_resValue, exp_q.pop_front());
          if (occ == 4) full_pops++;
        end
      end
      ifc_req__ENA       = acc;
      ifc_req_v          = (c % 4) + 1;
      ifc_resAccept__ENA = pp;
      if (acc) exp_q.push_back(32'h11 * ((c % 4) + 1));
      tick();
      occ = occ + int'(acc) - int'(pp);
    end
    ifc_req__ENA       = 1'b0;
    ifc_resAccept__ENA = 1'b0;
    check("ss_full_pop_seen", full_pops > 0, 1'b1);
    while (exp_q.size() > 0) pop_expect("ss_drain", exp_q.pop_front());
    check("ss_drained", ifc_resValue__RDY, 1'b0);

    // Reset with three requests in flight: nothing emerges, table is cleared again.
    do_write(8'h40, 32'h0000_1234);
    issue("fl1", 32'h10);
    issue("fl2", 32'h20);
    issue("fl3", 32'h40);
    nRST = 1'b0;
    tick();
    check("rst2_val_rdy", ifc_resValue__RDY, 1'b0);
    check("rst2_value", ifc_resValue, 32'h0);
    check("rst2_req_rdy", ifc_req__RDY, 1'b0);
    nRST = 1'b1;
    wait_clear("clear2");
    check("post_rst_empty", ifc_resValue__RDY, 1'b0);
    read_check("rd10_cleared", 32'h10, 32'h0);
    read_check("rd20_cleared", 32'h20, 32'h0);
    read_check("rd40_cleared", 32'h40, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
